// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status strobes out.
// master drives the line (pin side); slave is the receiver.
interface uart_rx_if;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;
    modport master (output rx_line, input rx_data, rx_valid, frame_err, rx_busy);
    modport slave  (input rx_line, output rx_data, rx_valid, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 LSB-first UART receiver with one-cycle valid / frame-error strobes.
// Define UART_RX_MAJORITY_EN to take every bit decision as a 2-of-3 vote of the last three samples.
module uart_rx_core #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

    state_t      state, state_n;
    logic [1:0]  sync;
    logic        rx_s, samp;
    logic [15:0] clk_cnt, clk_cnt_n;
    logic [2:0]  bit_index, bit_index_n;
    logic [7:0]  shift, shift_n, data_n;
    logic        valid_n, err_n;

    assign rx_s = sync[1];
    assign bus.rx_busy = state != IDLE;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk or posedge rst)
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], rx_s};
    assign samp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign samp = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync          <= 2'b11;
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_index     <= '0;
            shift         <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            sync          <= {sync[0], bus.rx_line};
            state         <= state_n;
            clk_cnt       <= clk_cnt_n;
            bit_index     <= bit_index_n;
            shift         <= shift_n;
            bus.rx_data   <= data_n;
            bus.rx_valid  <= valid_n;
            bus.frame_err <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        clk_cnt_n   = clk_cnt + 16'd1;
        bit_index_n = bit_index;
        shift_n     = shift;
        data_n      = bus.rx_data;
        valid_n     = 1'b0;
        err_n       = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n   = '0;
                bit_index_n = '0;
                state_n     = rx_s ? IDLE : START;
            end
            START: if (clk_cnt == HALF_END) begin
                clk_cnt_n = '0;
                state_n   = samp ? IDLE : DATA;
            end
            DATA: if (clk_cnt == BIT_END) begin
                clk_cnt_n   = '0;
                shift_n     = {samp, shift[7:1]};
                bit_index_n = bit_index + 3'd1;
                state_n     = (bit_index == 3'd7) ? STOP : DATA;
            end
            STOP: if (clk_cnt == BIT_END) begin
                clk_cnt_n = '0;
                valid_n   = samp;
                err_n     = !samp;
                data_n    = samp ? shift : bus.rx_data;
                state_n   = samp ? IDLE : RECOVER;
            end
            RECOVER: begin
                // a stuck-low line must not be mistaken for a new start bit
                clk_cnt_n = '0;
                state_n   = rx_s ? IDLE : RECOVER;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and random frames checked cycle by cycle against a timing model
// built from the edge arithmetic of the receiver (detect edge, sample offsets, strobe edge).
module tb_uart_rx_core;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD_RATE = 100000;
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0, bad = 0, cyc = 0;
    int t0, v_edge = -1, e_edge = -1, v_cnt = 0, e_cnt = 0, b_rise = -1, b_fall = -1;
    logic prev_busy = 1'b0;

    uart_rx_if bus ();
    uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // model: rx_s is the line two edges late; frame timing is counted in edges since detection
    logic m_s1, m_s2, h0, h1, rs, smp, m_valid, m_err, m_busy;
    logic [7:0] m_data, m_byte;
    int mode, k, j;
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_s1 = 1; m_s2 = 1; h0 = 1; h1 = 1; mode = 0; k = 0;
            m_data = 0; m_byte = 0; m_valid = 0; m_err = 0; m_busy = 0;
        end else begin
            rs = m_s2;
            smp = MAJ ? ((rs & h0) | (rs & h1) | (h0 & h1)) : rs;
            m_valid = 0;
            m_err = 0;
            if (mode == 0) begin
                if (!rs) begin mode = 1; k = 0; end
            end else if (mode == 1) begin
                k++;
                if (k == HALF) begin
                    if (smp) mode = 0;
                end else if (k > HALF && (k - HALF) % CPB == 0) begin
                    j = (k - HALF) / CPB;
                    if (j <= 8) m_byte[j-1] = smp;
                    else if (smp) begin m_valid = 1; m_data = m_byte; mode = 0; end
                    else begin m_err = 1; mode = 2; end
                end
            end else if (rs) mode = 0;
            m_busy = mode != 0;
            m_s2 = m_s1; m_s1 = bus.rx_line; h1 = h0; h0 = rs;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        check("rx_data", 32'(bus.rx_data), 32'(m_data));
        check("rx_valid", 32'(bus.rx_valid), 32'(m_valid));
        check("frame_err", 32'(bus.frame_err), 32'(m_err));
        check("rx_busy", 32'(bus.rx_busy), 32'(m_busy));
        if (bus.rx_valid) begin v_edge = cyc; v_cnt++; end
        if (bus.frame_err) begin e_edge = cyc; e_cnt++; end
        if (bus.rx_busy && !prev_busy) b_rise = cyc;
        if (!bus.rx_busy && prev_busy) b_fall = cyc;
        prev_busy = bus.rx_busy;
    end

    // called on a negedge; edge t0 is the first edge that samples the start bit
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        t0 = cyc + 1;
        for (int c = 0; c < 10 * CPB; c++) begin
            bus.rx_line = (c == glitch) ? ~f[c/CPB] : f[c/CPB];
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus.rx_line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0, e0, ev;
        bus.rx_line = 1'b1;
        repeat (3) @(negedge clk);
        check("reset rx_data", 32'(bus.rx_data), 32'h00);
        check("reset rx_valid", 32'(bus.rx_valid), 32'h0);
        check("reset frame_err", 32'(bus.frame_err), 32'h0);
        check("reset rx_busy", 32'(bus.rx_busy), 32'h0);
        rst = 1'b0;
        idle(5);

        send_frame(8'hA5, 1'b1, -1);
        idle(5);
        check("a5 valid edge", 32'(v_edge - t0), 32'd97);
        check("a5 data", 32'(bus.rx_data), 32'hA5);
        check("a5 busy rise", 32'(b_rise - t0), 32'd2);
        check("a5 busy fall", 32'(b_fall - t0), 32'd97);
        check("a5 no err", 32'(e_cnt), 32'd0);

        v0 = v_cnt;
        t0 = cyc + 1;
        bus.rx_line = 1'b0;
        repeat (3) @(negedge clk);
        idle(10);
        check("glitch busy rise", 32'(b_rise - t0), 32'd2);
        check("glitch busy fall", 32'(b_fall - t0), 32'd7);
        check("glitch no valid", 32'(v_cnt - v0), 32'd0);
        check("glitch no err", 32'(e_cnt), 32'd0);

        send_frame(8'h3C, 1'b0, -1);
        bus.rx_line = 1'b0;
        repeat (30) @(negedge clk);
        idle(5);
        check("3c err edge", 32'(e_edge - t0), 32'd97);
        check("3c err count", 32'(e_cnt), 32'd1);
        check("3c data held", 32'(bus.rx_data), 32'hA5);
        check("3c busy fall", 32'(b_fall - t0), 32'd132);
        send_frame(8'h11, 1'b1, -1);
        idle(5);
        check("11 data", 32'(bus.rx_data), 32'h11);

        send_frame(8'h00, 1'b1, -1);
        v0 = v_edge;
        check("b2b first data", 32'(bus.rx_data), 32'h00);
        send_frame(8'hFF, 1'b1, -1);
        idle(5);
        check("b2b spacing", 32'(v_edge - v0), 32'd100);
        check("b2b second data", 32'(bus.rx_data), 32'hFF);

        v0 = v_cnt;
        ev = e_cnt;
        begin
            logic [9:0] f;
            f = {1'b1, 8'h5A, 1'b0};
            for (int c = 0; c < 5 * CPB + 4; c++) begin
                bus.rx_line = f[c/CPB];
                @(negedge clk);
            end
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst rx_data", 32'(bus.rx_data), 32'h00);
        check("rst rx_valid", 32'(bus.rx_valid), 32'h0);
        check("rst frame_err", 32'(bus.frame_err), 32'h0);
        check("rst rx_busy", 32'(bus.rx_busy), 32'h0);
        @(negedge clk);
        bus.rx_line = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        idle(20);
        check("rst no strobe", 32'(v_cnt - v0 + e_cnt - ev), 32'd0);
        send_frame(8'h5A, 1'b1, -1);
        idle(5);
        check("5a after rst", 32'(bus.rx_data), 32'h5A);

        send_frame(8'h00, 1'b1, 45);
        idle(5);
        check("bit3 glitch data", 32'(bus.rx_data), MAJ ? 32'h00 : 32'h08);

        for (int i = 0; i < 40; i++) begin
            logic stop;
            stop = $urandom_range(0, 4) != 0;
            send_frame(8'($urandom), stop, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10 * CPB - 1)) : -1);
            if (!stop) begin
                bus.rx_line = 1'b0;
                repeat ($urandom_range(0, 30)) @(negedge clk);
            end
            idle($urandom_range(0, 20));
        end
        idle(150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
